pov_char_scheduler: RTL and testbench
=====================================

// Module: pov_char_scheduler
// PURPOSE
//   Sequences a received 77-bit string (11 chars x 7 bits) onto the POV LED column driver, one character per time slot.
//   Sits between the UART receiver top (String/ready) and the LED output stage.
//   Each display frame starts on the rotation index pulse.
//   A new string is double-buffered and only swapped in at a frame boundary, so a frame never shows two strings mixed.
// PARAMETERS
//   NCHAR   11  characters per string
//   CHAR_W  7   bits per character
//   DWELL   64  clk cycles each character is driven (>=1)
//   GAP     16  blank clk cycles after each character (>=0; 0 = no blank slot)
// PORTS
//   clk         in   1               system clock, rising edge
//   reset       in   1               asynchronous, active-low reset
//   ready       in   1               receiver string-complete flag; load on rising edge
//   String      in   NCHAR*CHAR_W    [0:76]; char k = String[7k : 7k+6]
//   index       in   1               rotation index, 1-cycle pulse, already synchronous to clk
//   CharSalida  out  CHAR_W          [0:6] column data for current character, 0 when blank
//   char_valid  out  1               CharSalida holds a character (high in SHOW only)
//   char_idx    out  4               index of character being shown, 0..NCHAR-1
//   frame_done  out  1               1-cycle pulse after last character's gap
//   busy        out  1               high in SHOW or GAP
//   overrun     out  1               sticky: index arrived while busy
// BEHAVIOUR
//   - Reset: all outputs 0, pending/active buffers 0, pend_vld 0, ready edge reg 0, state IDLE.
//     Reset mid-frame aborts immediately and returns to IDLE.
//   - Load: ready rising edge (ready & ~ready_q) -> pending <= String, pend_vld <= 1, in any state.
//     A later load overwrites an unswapped pending string.
//   - States:
//     - IDLE: index ignored; on load -> WAIT_IDX.
//     - WAIT_IDX: on index, if pend_vld then active <= pending, pend_vld <= 0; char_idx <= 0, dwell cnt <= 0 -> SHOW.
//     - SHOW: CharSalida = active[7*char_idx +: 7], char_valid = 1.
//       After DWELL cycles: -> GAP if GAP>0, else advance.
//     - GAP: CharSalida = 0, char_valid = 0 for GAP cycles, then advance.
//     - advance: if char_idx < NCHAR-1 then char_idx++ -> SHOW; else frame_done pulses 1 cycle, char_idx <= 0 -> WAIT_IDX.
//   - Latency: index at cycle t -> char_valid = 1 with char 0 at t+1.
//     Frame = NCHAR*(DWELL+GAP) cycles; frame_done asserts in the cycle after the final slot ends.
//   - Index in SHOW/GAP: ignored for sequencing; sets overrun (cleared only by reset). Current frame completes normally.
//   - Load and index in the same cycle in WAIT_IDX: the swap uses the old pending contents (or keeps active if none).
//     The new string stays pending for the next index.
//   - Index in the same cycle frame_done pulses: overrun is set; the next frame does not start until the next index.
//   - Outputs registered; CharSalida, char_valid and char_idx change together on the same edge.
//   - Counters: dwell/gap counter width = clog2(max(DWELL,GAP)+1); no wrap beyond terminal count.
// TESTING  (DWELL=4, GAP=2, NCHAR=11)
//   1. Reset asserted mid-SHOW -> all outputs 0 asynchronously; after release, index ignored until a load occurs.
//   2. Load String with char k = k+1, then index at t:
//      - t+1..t+4: CharSalida=7'd1, char_idx=0
//      - t+5..t+6: CharSalida=0, char_valid=0
//      - t+7: CharSalida=7'd2
//      - frame_done at t+67
//   3. GAP=0 build: chars back-to-back, char_valid never drops across the 44-cycle frame.
//   4. Load string B mid-frame of A -> remainder of frame still shows A; next index shows B char 0.
//   5. Extra index pulse in GAP of char 3 -> overrun=1 and stays 1; frame continues; char_idx sequence unbroken.
//   6. ready edge and index in the same WAIT_IDX cycle -> frame shows the previous string; the following frame shows the new one.

Source files
------------

// File: rtl/pov_char_scheduler.sv
// POV character scheduler: double-buffers a received string and drives one
// character per time slot onto the LED column, framed by the rotation index.
module pov_char_scheduler #(
  parameter int NCHAR  = 11,
  parameter int CHAR_W = 7,
  parameter int DWELL  = 64,
  parameter int GAP    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ready,
  input  logic [0:NCHAR*CHAR_W-1] String,
  input  logic                    index,
  output logic [0:CHAR_W-1]       CharSalida,
  output logic                    char_valid,
  output logic [3:0]              char_idx,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    overrun
);

  localparam int CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [3:0]       LAST_IDX   = 4'(NCHAR - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_IDX, S_SHOW, S_GAP} state_t;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [0:NCHAR*CHAR_W-1]   r_pending;
  logic [0:NCHAR*CHAR_W-1]   r_active;
  logic                      r_pend_vld;
  logic                      r_ready_q;
  logic [0:CHAR_W-1]         r_char;
  logic                      r_valid;
  logic [3:0]                r_idx;
  logic                      r_done;
  logic                      r_busy;
  logic                      r_ovr;

  logic                      w_load;
  logic                      w_slot_end;
  logic [3:0]                w_next_idx;
  logic [0:NCHAR*CHAR_W-1]   w_start_buf;
  logic [0:CHAR_W-1]         w_first_char;
  logic [0:CHAR_W-1]         w_next_char;

  assign w_load       = ready & ~r_ready_q;
  assign w_next_idx   = r_idx + 4'd1;
  assign w_start_buf  = r_pend_vld ? r_pending : r_active;
  assign w_first_char = w_start_buf[0:CHAR_W-1];

  // A slot ends after the gap, or straight after the dwell when there is no gap.
  assign w_slot_end = ((r_state == S_SHOW) && (r_cnt == DWELL_LAST) && (GAP == 0)) ||
                      ((r_state == S_GAP)  && (r_cnt == GAP_LAST));

  always_comb begin
    w_next_char = '0;
    for (int unsigned k = 0; k < NCHAR; k++) begin
      if (4'(k) == w_next_idx) w_next_char = r_active[k*CHAR_W +: CHAR_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pending  <= '0;
      r_active   <= '0;
      r_pend_vld <= 1'b0;
      r_ready_q  <= 1'b0;
      r_char     <= '0;
      r_valid    <= 1'b0;
      r_idx      <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_ready_q <= ready;
      r_done    <= 1'b0;
      if (index && ((r_state == S_SHOW) || (r_state == S_GAP) || r_done)) r_ovr <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_load) r_state <= S_WAIT_IDX;
        end
        S_WAIT_IDX: begin
          if (index && !r_done) begin
            if (r_pend_vld) begin
              r_active   <= r_pending;
              r_pend_vld <= 1'b0;
            end
            r_idx   <= '0;
            r_cnt   <= '0;
            r_char  <= w_first_char;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (r_cnt != DWELL_LAST) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (GAP > 0) begin
            r_cnt   <= '0;
            r_char  <= '0;
            r_valid <= 1'b0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_cnt != GAP_LAST) r_cnt <= r_cnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_slot_end) begin
        r_cnt <= '0;
        if (r_idx != LAST_IDX) begin
          r_idx   <= w_next_idx;
          r_char  <= w_next_char;
          r_valid <= 1'b1;
          r_state <= S_SHOW;
        end else begin
          r_idx   <= '0;
          r_char  <= '0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_WAIT_IDX;
        end
      end

      // Placed last so a load coinciding with a swap leaves the new string pending.
      if (w_load) begin
        r_pending  <= String;
        r_pend_vld <= 1'b1;
      end
    end
  end

  assign CharSalida = r_char;
  assign char_valid = r_valid;
  assign char_idx   = r_idx;
  assign frame_done = r_done;
  assign busy       = r_busy;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_pov_char_scheduler.sv
// Bench for pov_char_scheduler: a GAP=2 and a GAP=0 instance checked against a
// slot-timing reference model (elapsed cycles since the accepted index pulse).
module tb_pov_char_scheduler;
  localparam int NCHAR  = 11;
  localparam int CHAR_W = 7;
  localparam int SW     = NCHAR * CHAR_W;
  localparam int D      = 4;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          ready = 1'b0;
  logic          index = 1'b0;
  logic [0:SW-1] str   = '0;

  logic [0:CHAR_W-1] cs_a, cs_b;
  logic              cv_a, cv_b, fd_a, fd_b, bz_a, bz_b, ov_a, ov_b;
  logic [3:0]        ci_a, ci_b;
  logic [14:0]       obs_a, obs_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  assign obs_a = {cs_a, cv_a, ci_a, fd_a, bz_a, ov_a};
  assign obs_b = {cs_b, cv_b, ci_b, fd_b, bz_b, ov_b};

  always #5 clk = ~clk;

  pov_char_scheduler #(.NCHAR(NCHAR), .CHAR_W(CHAR_W), .DWELL(D), .GAP(2)) dut_a (
    .clk(clk), .reset(reset), .ready(ready), .String(str), .index(index),
    .CharSalida(cs_a), .char_valid(cv_a), .char_idx(ci_a),
    .frame_done(fd_a), .busy(bz_a), .overrun(ov_a));

  pov_char_scheduler #(.NCHAR(NCHAR), .CHAR_W(CHAR_W), .DWELL(D), .GAP(0)) dut_b (
    .clk(clk), .reset(reset), .ready(ready), .String(str), .index(index),
    .CharSalida(cs_b), .char_valid(cv_b), .char_idx(ci_b),
    .frame_done(fd_b), .busy(bz_b), .overrun(ov_b));

  // Reference model: per instance, pending/active strings and the cycle of the accepted index.
  logic [0:SW-1] m_pend [2];
  logic [0:SW-1] m_act  [2];
  bit            m_pvld [2];
  bit            m_armed[2];
  bit            m_started[2];
  bit            m_ovr  [2];
  int            m_t0   [2];
  logic          m_rq;

  function automatic int gap_of(int c);
    return (c == 0) ? 2 : 0;
  endfunction

  function automatic logic [6:0] char_of(logic [0:SW-1] s, int k);
    return s[k*CHAR_W +: CHAR_W];
  endfunction

  function automatic logic [0:SW-1] rand_str();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[SW-1:0];
  endfunction

  always @(posedge clk or negedge reset) begin : mdl
    if (!reset) begin
      for (int c = 0; c < 2; c++) begin
        m_pend[c] = '0; m_act[c] = '0; m_pvld[c] = 0; m_armed[c] = 0;
        m_started[c] = 0; m_ovr[c] = 0; m_t0[c] = 0;
      end
      m_rq = 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin : per_inst
        int L, e;
        bit bsy, dn;
        L   = NCHAR * (D + gap_of(c));
        e   = cyc - m_t0[c];
        bsy = m_started[c] && e >= 1 && e <= L;
        dn  = m_started[c] && e == L + 1;
        if (index) begin
          if (bsy || dn) m_ovr[c] = 1'b1;
          else if (m_armed[c]) begin
            if (m_pvld[c]) begin m_act[c] = m_pend[c]; m_pvld[c] = 0; end
            m_started[c] = 1; m_t0[c] = cyc;
          end
        end
        if (ready && !m_rq) begin m_pend[c] = str; m_pvld[c] = 1; m_armed[c] = 1; end
      end
      m_rq = ready;
    end
    cyc++;
  end

  function automatic logic [14:0] exp_out(int c);
    int g, L, e, slot, off;
    logic [6:0] ch; logic v, dn, bz; logic [3:0] ix;
    g = gap_of(c); L = NCHAR * (D + g); e = cyc - m_t0[c];
    ch = '0; v = 0; dn = 0; bz = 0; ix = '0;
    if (m_started[c]) begin
      if (e >= 1 && e <= L) begin
        slot = (e - 1) / (D + g); off = (e - 1) % (D + g);
        bz = 1; ix = 4'(slot);
        if (off < D) begin v = 1; ch = m_act[c][slot*CHAR_W +: CHAR_W]; end
      end else if (e == L + 1) dn = 1;
    end
    return {ch, v, ix, dn, bz, m_ovr[c]};
  endfunction

  task automatic step(input logic i_idx, input logic i_rdy);
    index = i_idx;
    ready = i_rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int t;
    step(0, 0); step(0, 0);
    total++; if (obs_a !== '0 || obs_b !== '0) begin bad++; $display("FAIL reset_hold: got %h/%h want 0", obs_a, obs_b); end
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(i % 3 == 0, 0);
      total++; if (obs_a !== exp_out(0)) begin bad++; $display("FAIL model_a cyc=%0d: got %h want %h", cyc, obs_a, exp_out(0)); end
      total++; if (bz_a !== 1'b0 || cv_a !== 1'b0) begin bad++; $display("FAIL idle_ignore: got busy=%b valid=%b want 0", bz_a, cv_a); end
    end
    str = rand_str(); step(0, 1); step(0, 0); t = cyc; step(1, 0);
    for (int i = 0; i < 6; i++) begin
      total++; if (obs_a !== exp_out(0)) begin bad++; $display("FAIL model_a cyc=%0d: got %h want %h", cyc, obs_a, exp_out(0)); end
      total++; if (obs_b !== exp_out(1)) begin bad++; $display("FAIL model_b cyc=%0d: got %h want %h", cyc, obs_b, exp_out(1)); end
      step(0, 0);
    end
    total++; if (cv_a !== 1'b1) begin bad++; $display("FAIL pre_reset_show: got %b want 1", cv_a); end
    #3 reset = 1'b0;
    #1;
    total++; if (obs_a !== '0 || obs_b !== '0) begin bad++; $display("FAIL async_reset: got %h/%h want 0", obs_a, obs_b); end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(i == 1, 0);
      total++; if (obs_a !== exp_out(0)) begin bad++; $display("FAIL model_a cyc=%0d: got %h want %h", cyc, obs_a, exp_out(0)); end
      total++; if (bz_a !== 1'b0 || bz_b !== 1'b0) begin bad++; $display("FAIL post_reset_idle: got %b/%b want 0", bz_a, bz_b); end
    end
  endtask

  task automatic test_basic();
    int t, e;
    for (int k = 0; k < NCHAR; k++) str[k*CHAR_W +: CHAR_W] = 7'(k + 1);
    step(0, 1); step(0, 0); step(0, 0); t = cyc; step(1, 0);
    for (int i = 0; i < 70; i++) begin
      e = cyc - t;
      total++; if (obs_a !== exp_out(0)) begin bad++; $display("FAIL model_a cyc=%0d: got %h want %h", cyc, obs_a, exp_out(0)); end
      total++; if (obs_b !== exp_out(1)) begin bad++; $display("FAIL model_b cyc=%0d: got %h want %h", cyc, obs_b, exp_out(1)); end
      if (e >= 1 && e <= 4) begin
        total++; if (cs_a !== 7'd1 || ci_a !== 4'd0 || cv_a !== 1'b1) begin bad++; $display("FAIL char0_dwell e=%0d: got %h/%0d/%b want 01/0/1", e, cs_a, ci_a, cv_a); end
      end
      if (e == 5 || e == 6) begin
        total++; if (cs_a !== 7'd0 || cv_a !== 1'b0) begin bad++; $display("FAIL gap0 e=%0d: got %h/%b want 00/0", e, cs_a, cv_a); end
      end
      if (e == 7) begin
        total++; if (cs_a !== 7'd2) begin bad++; $display("FAIL char1 e=%0d: got %h want 02", e, cs_a); end
      end
      total++; if (fd_a !== (e == 67)) begin bad++; $display("FAIL done_a e=%0d: got %b want %b", e, fd_a, e == 67); end
      total++; if (cv_b !== (e >= 1 && e <= 44)) begin bad++; $display("FAIL nogap_valid e=%0d: got %b want %b", e, cv_b, e >= 1 && e <= 44); end
      total++; if (fd_b !== (e == 45)) begin bad++; $display("FAIL done_b e=%0d: got %b want %b", e, fd_b, e == 45); end
      step(0, 0);
    end
  endtask

  task automatic test_midframe();
    int t, e;
    logic [0:SW-1] sa, sb;
    sa = rand_str(); sb = rand_str();
    str = sa; step(0, 1); step(0, 0); t = cyc; step(1, 0);
    for (int i = 0; i < 72; i++) begin
      e = cyc - t;
      total++; if (obs_a !== exp_out(0)) begin bad++; $display("FAIL model_a cyc=%0d: got %h want %h", cyc, obs_a, exp_out(0)); end
      total++; if (obs_b !== exp_out(1)) begin bad++; $display("FAIL model_b cyc=%0d: got %h want %h", cyc, obs_b, exp_out(1)); end
      if (cv_a === 1'b1) begin
        total++; if (cs_a !== char_of(sa, (e - 1) / 6)) begin bad++; $display("FAIL frame_keeps_a e=%0d: got %h want %h", e, cs_a, char_of(sa, (e - 1) / 6)); end
      end
      if (e == 20) str = sb;
      step(0, e == 20);
    end
    t = cyc; step(1, 0);
    total++; if (cs_a !== char_of(sb, 0)) begin bad++; $display("FAIL next_frame_b: got %h want %h", cs_a, char_of(sb, 0)); end
    for (int i = 0; i < 70; i++) begin
      total++; if (obs_a !== exp_out(0)) begin bad++; $display("FAIL model_a cyc=%0d: got %h want %h", cyc, obs_a, exp_out(0)); end
      total++; if (obs_b !== exp_out(1)) begin bad++; $display("FAIL model_b cyc=%0d: got %h want %h", cyc, obs_b, exp_out(1)); end
      step(0, 0);
    end
  endtask

  task automatic test_same_cycle();
    int t, e;
    logic [0:SW-1] sc, sd;
    sc = rand_str(); sd = rand_str();
    str = sc; step(0, 1); step(0, 0);
    str = sd; t = cyc; step(1, 1);
    for (int i = 0; i < 68; i++) begin
      e = cyc - t;
      total++; if (obs_a !== exp_out(0)) begin bad++; $display("FAIL model_a cyc=%0d: got %h want %h", cyc, obs_a, exp_out(0)); end
      total++; if (obs_b !== exp_out(1)) begin bad++; $display("FAIL model_b cyc=%0d: got %h want %h", cyc, obs_b, exp_out(1)); end
      if (cv_a === 1'b1) begin
        total++; if (cs_a !== char_of(sc, (e - 1) / 6)) begin bad++; $display("FAIL same_cycle_old e=%0d: got %h want %h", e, cs_a, char_of(sc, (e - 1) / 6)); end
      end
      step(0, 0);
    end
    step(1, 0);
    total++; if (cs_a !== char_of(sd, 0) || cs_b !== char_of(sd, 0)) begin bad++; $display("FAIL same_cycle_new: got %h/%h want %h", cs_a, cs_b, char_of(sd, 0)); end
    for (int i = 0; i < 68; i++) begin
      total++; if (obs_a !== exp_out(0)) begin bad++; $display("FAIL model_a cyc=%0d: got %h want %h", cyc, obs_a, exp_out(0)); end
      total++; if (obs_b !== exp_out(1)) begin bad++; $display("FAIL model_b cyc=%0d: got %h want %h", cyc, obs_b, exp_out(1)); end
      step(0, 0);
    end
  endtask

  task automatic test_done_collision();
    int t, e;
    str = rand_str(); step(0, 1); step(0, 0); t = cyc; step(1, 0);
    for (int i = 0; i < 120; i++) begin
      e = cyc - t;
      total++; if (obs_a !== exp_out(0)) begin bad++; $display("FAIL model_a cyc=%0d: got %h want %h", cyc, obs_a, exp_out(0)); end
      total++; if (obs_b !== exp_out(1)) begin bad++; $display("FAIL model_b cyc=%0d: got %h want %h", cyc, obs_b, exp_out(1)); end
      if (e == 66) begin
        total++; if (ov_a !== 1'b0) begin bad++; $display("FAIL ovr_before_done: got %b want 0", ov_a); end
      end
      if (e == 68) begin
        total++; if (ov_a !== 1'b1 || bz_a !== 1'b0 || cv_a !== 1'b0) begin bad++; $display("FAIL done_collision: got ovr=%b busy=%b valid=%b want 1/0/0", ov_a, bz_a, cv_a); end
      end
      step(e == 67, 0);
    end
  endtask

  task automatic test_overrun();
    int t, e;
    reset = 1'b0; step(0, 0); reset = 1'b1;
    str = rand_str(); step(0, 1); step(0, 0); t = cyc; step(1, 0);
    for (int i = 0; i < 80; i++) begin
      e = cyc - t;
      total++; if (obs_a !== exp_out(0)) begin bad++; $display("FAIL model_a cyc=%0d: got %h want %h", cyc, obs_a, exp_out(0)); end
      total++; if (obs_b !== exp_out(1)) begin bad++; $display("FAIL model_b cyc=%0d: got %h want %h", cyc, obs_b, exp_out(1)); end
      if (e <= 66) begin
        total++; if (ci_a !== 4'((e - 1) / 6)) begin bad++; $display("FAIL idx_seq e=%0d: got %0d want %0d", e, ci_a, (e - 1) / 6); end
      end
      if (e == 23) begin
        total++; if (ov_a !== 1'b0) begin bad++; $display("FAIL ovr_clear: got %b want 0", ov_a); end
      end
      if (e >= 24) begin
        total++; if (ov_a !== 1'b1) begin bad++; $display("FAIL ovr_sticky e=%0d: got %b want 1", e, ov_a); end
      end
      step(e == 23, 0);
    end
  endtask

  task automatic test_random();
    logic rdy;
    rdy = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      str = rand_str();
      if ($urandom_range(0, 7) == 0) rdy = ~rdy;
      step($urandom_range(0, 24) == 0, rdy);
      total++; if (obs_a !== exp_out(0)) begin bad++; $display("FAIL rand_a cyc=%0d: got %h want %h", cyc, obs_a, exp_out(0)); end
      total++; if (obs_b !== exp_out(1)) begin bad++; $display("FAIL rand_b cyc=%0d: got %h want %h", cyc, obs_b, exp_out(1)); end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_midframe();
    test_same_cycle();
    test_done_collision();
    test_overrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
